instruction_fetch_unit: RTL and testbench

//  Program-counter sequencer sitting between the CPU control path and the

---
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit.sv | 98 +++++++++
 tb/tb_instruction_fetch_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bus: the instruction memory port, the IF/ID output register and CPU control.
// The master modport is the fetch unit; the slave modport is memory, decode and control.
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_req;
    logic              halted;
    logic              fault;

    modport master (
        output imem_addr, instr, instr_pc, instr_valid, halted, fault,
        input  imem_data, instr_ready, redirect_valid, redirect_pc, halt_req
    );

    modport slave (
        input  imem_addr, instr, instr_pc, instr_valid, halted, fault,
        output imem_data, instr_ready, redirect_valid, redirect_pc, halt_req
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// PC sequencer feeding the IF/ID register, with backpressure, redirect and halt.
// Define FETCH_FAULT_EN to trap fetches at pc >= MEM_DEPTH (adds the FAULT state).
module instruction_fetch_unit #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MEM_DEPTH = 128,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus
);
    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALTED
`ifdef FETCH_FAULT_EN
        , ST_FAULT
`endif
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              r_valid;
    logic              r_halted;
    logic              w_xfer;
    logic              w_load_ok;

    assign w_xfer    = r_valid && bus.instr_ready;
    assign w_load_ok = !r_valid || bus.instr_ready;

`ifdef FETCH_FAULT_EN
    logic r_fault;
    logic w_out_of_range;
    assign w_out_of_range = (32'(r_pc) >= MEM_DEPTH);
    assign bus.fault      = r_fault;
`else
    assign bus.fault      = 1'b0;
`endif

    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_valid;
    assign bus.halted      = r_halted;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_pc       <= ADDR_W'(RESET_PC);
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
`ifdef FETCH_FAULT_EN
            r_fault    <= 1'b0;
`endif
        end else if (bus.redirect_valid) begin
            // Redirect owns the pc and flushes; a simultaneous halt still decides the state.
            r_pc     <= bus.redirect_pc;
            r_valid  <= 1'b0;
            r_state  <= bus.halt_req ? ST_HALTED : ST_RUN;
            r_halted <= bus.halt_req;
`ifdef FETCH_FAULT_EN
            r_fault  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.halt_req) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                        if (w_xfer) r_valid <= 1'b0;
                    end else if (w_load_ok) begin
`ifdef FETCH_FAULT_EN
                        if (w_out_of_range) begin
                            r_state <= ST_FAULT;
                            r_fault <= 1'b1;
                            r_valid <= 1'b0;
                        end else
`endif
                        begin
                            r_instr    <= bus.imem_data;
                            r_instr_pc <= r_pc;
                            r_valid    <= 1'b1;
                            r_pc       <= r_pc + ADDR_W'(1);
                        end
                    end
                end
                // HALTED and FAULT only drain the held instruction.
                default: begin
                    if (w_xfer) r_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory word at address a is {20'hC0DE0, a}.
// A second instance with RESET_PC=126 exercises the top of the populated range.
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.ADDR_W(12), .DATA_W(32)) bus  ();
    instruction_fetch_unit_if #(.ADDR_W(12), .DATA_W(32)) bus2 ();

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {20'hC0DE0, a};
    endfunction

    assign bus.imem_data  = mem_word(bus.imem_addr);
    assign bus2.imem_data = mem_word(bus2.imem_addr);

    instruction_fetch_unit #(.ADDR_W(12), .DATA_W(32), .MEM_DEPTH(128), .RESET_PC(0)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    instruction_fetch_unit #(.ADDR_W(12), .DATA_W(32), .MEM_DEPTH(128), .RESET_PC(126)) u_dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [11:0] pc, input logic [11:0] addr);
        chk({tag, ".valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, ".pc"},    32'(bus.instr_pc),    32'(pc));
        chk({tag, ".instr"}, bus.instr,            mem_word(pc));
        chk({tag, ".addr"},  32'(bus.imem_addr),   32'(addr));
    endtask

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        bus.instr_ready  = 1'b1; bus.redirect_valid  = 1'b0; bus.redirect_pc  = '0; bus.halt_req  = 1'b0;
        bus2.instr_ready = 1'b1; bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0; bus2.halt_req = 1'b0;
        step(2);
        chk("rst.valid",  32'(bus.instr_valid), 32'd0);
        chk("rst.instr",  bus.instr,            32'd0);
        chk("rst.pc",     32'(bus.instr_pc),    32'd0);
        chk("rst.addr",   32'(bus.imem_addr),   32'd0);
        chk("rst.halted", 32'(bus.halted),      32'd0);
        chk("rst.fault",  32'(bus.fault),       32'd0);

        // Streaming at full rate
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_out("stream", 12'(i), 12'(i + 1));
        end

        // Backpressure holds the output register and pc
        bus.instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk_out("stall", 12'd2, 12'd3);
        end
        bus.instr_ready = 1'b1;
        for (int i = 3; i < 6; i++) begin
            step(1);
            chk_out("resume", 12'(i), 12'(i + 1));
        end

        // Redirect while stalled flushes the held instruction
        bus.instr_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 12'h040;
        step(1);
        chk("redir.valid", 32'(bus.instr_valid), 32'd0);
        chk("redir.addr",  32'(bus.imem_addr),   32'h040);
        bus.redirect_valid = 1'b0; bus.instr_ready = 1'b1;
        step(1);
        chk_out("redir.tgt", 12'h040, 12'h041);

        // Halt with instr_pc=2 held and imem_addr=3
        bus.redirect_valid = 1'b1; bus.redirect_pc = 12'h002;
        step(1);
        bus.redirect_valid = 1'b0;
        step(1);
        chk_out("pre_halt", 12'd2, 12'd3);
        bus.instr_ready = 1'b0; bus.halt_req = 1'b1;
        step(1);
        chk("halt.halted", 32'(bus.halted), 32'd1);
        chk_out("halt.hold", 12'd2, 12'd3);
        bus.halt_req = 1'b0;
        step(1);
        chk_out("halt.hold2", 12'd2, 12'd3);
        bus.instr_ready = 1'b1;
        step(1);
        chk("halt.drain",  32'(bus.instr_valid), 32'd0);
        step(3);
        chk("halt.idle",   32'(bus.instr_valid), 32'd0);
        chk("halt.addr",   32'(bus.imem_addr),   32'd3);
        chk("halt.stays",  32'(bus.halted),      32'd1);

        // Redirect and halt together: pc from redirect, state stays halted
        bus.redirect_valid = 1'b1; bus.redirect_pc = 12'h010; bus.halt_req = 1'b1;
        step(1);
        bus.redirect_valid = 1'b0; bus.halt_req = 1'b0;
        chk("rh.addr",   32'(bus.imem_addr),   32'h010);
        chk("rh.halted", 32'(bus.halted),      32'd1);
        step(1);
        chk("rh.valid",  32'(bus.instr_valid), 32'd0);
        chk("rh.addr2",  32'(bus.imem_addr),   32'h010);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 12'h020;
        step(1);
        bus.redirect_valid = 1'b0;
        chk("unhalt.halted", 32'(bus.halted),    32'd0);
        chk("unhalt.addr",   32'(bus.imem_addr), 32'h020);
        step(1);
        chk_out("unhalt.tgt", 12'h020, 12'h021);

        // Transfer and redirect on the same edge
        bus.redirect_valid = 1'b1; bus.redirect_pc = 12'h030;
        step(1);
        bus.redirect_valid = 1'b0;
        chk("xr.valid", 32'(bus.instr_valid), 32'd0);
        step(1);
        chk_out("xr.tgt", 12'h030, 12'h031);

`ifdef FETCH_FAULT_EN
        bus.redirect_valid = 1'b1; bus.redirect_pc = 12'hFFE;
        step(1);
        bus.redirect_valid = 1'b0;
        step(1);
        chk("hi.fault", 32'(bus.fault),       32'd1);
        chk("hi.valid", 32'(bus.instr_valid), 32'd0);
        bus.redirect_valid = 1'b1; bus.redirect_pc = 12'h000;
        step(1);
        bus.redirect_valid = 1'b0;
        step(1);
        chk_out("hi.clear", 12'h000, 12'h001);
`else
        // Out-of-range fetch without fault checking, plus pc wrap
        bus.redirect_valid = 1'b1; bus.redirect_pc = 12'hFFE;
        step(1);
        bus.redirect_valid = 1'b0;
        step(1);
        chk_out("wrap.ffe", 12'hFFE, 12'hFFF);
        step(1);
        chk_out("wrap.fff", 12'hFFF, 12'h000);
        step(1);
        chk_out("wrap.000", 12'h000, 12'h001);
        chk("wrap.fault", 32'(bus.fault), 32'd0);
`endif

        // Reset while halted with a held instruction
        bus.instr_ready = 1'b0; bus.halt_req = 1'b1;
        step(1);
        chk("r6.halted", 32'(bus.halted),      32'd1);
        chk("r6.valid",  32'(bus.instr_valid), 32'd1);
        bus.halt_req = 1'b0; rst_n = 1'b0;
        step(1);
        chk("r6.valid0",  32'(bus.instr_valid), 32'd0);
        chk("r6.instr0",  bus.instr,            32'd0);
        chk("r6.pc0",     32'(bus.instr_pc),    32'd0);
        chk("r6.halted0", 32'(bus.halted),      32'd0);
        chk("r6.addr0",   32'(bus.imem_addr),   32'd0);
        rst_n = 1'b1; bus.instr_ready = 1'b1;
        step(1);
        chk_out("r6.resume", 12'h000, 12'h001);

        // Second instance: RESET_PC=126, crossing MEM_DEPTH
        rst2_n = 1'b1;
        step(1);
        chk("d2.pc126",  32'(bus2.instr_pc), 32'd126);
        chk("d2.ins126", bus2.instr,         mem_word(12'd126));
        step(1);
        chk("d2.pc127",  32'(bus2.instr_pc), 32'd127);
        step(1);
`ifdef FETCH_FAULT_EN
        chk("d2.fault",  32'(bus2.fault),       32'd1);
        chk("d2.fvalid", 32'(bus2.instr_valid), 32'd0);
        bus2.redirect_valid = 1'b1; bus2.redirect_pc = 12'h000;
        step(1);
        bus2.redirect_valid = 1'b0;
        chk("d2.fclr",   32'(bus2.fault),       32'd0);
        step(1);
        chk("d2.pc0",    32'(bus2.instr_pc),    32'd0);
        chk("d2.valid0", 32'(bus2.instr_valid), 32'd1);
`else
        chk("d2.pc128",  32'(bus2.instr_pc),    32'd128);
        chk("d2.ins128", bus2.instr,            mem_word(12'd128));
        chk("d2.fault",  32'(bus2.fault),       32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
